// File: rtl/mem_array.sv
// rtl/mem_array.sv - multi-channel gamma-cycle programmable spike delay array
//
// Each of NUM_CH channels takes the first spike it sees in a gamma cycle and
// re-emits it 1+D aclk cycles later, where D is the per-channel delay latched
// on gstart. If the fire time would fall past the end of the gamma cycle, the
// spike is dropped and late[c] pulses for one cycle instead.
//
// Optional feature macro: MEM_ARRAY_PULSE_EN
//   defined   - out[c] is a PULSE_WIDTH-cycle pulse (truncated by gstart)
//   undefined - out[c] is a level held from fire time until the next gstart
//
// Ports:
//   aclk    in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   gstart  in   one-cycle pulse, gamma time 0 of a new gamma cycle
//   in      in   [NUM_CH]      spike inputs, level sampled
//   delay   in   [NUM_CH*DW]   per-channel delay, sampled in the gstart cycle
//   out     out  [NUM_CH]      delayed spikes, registered
//   late    out  [NUM_CH]      one-cycle flag, spike dropped as too late

module mem_array #(
    parameter int NUM_CH            = 8,
    parameter int GAMMA_CYCLE_WIDTH = 128,
    parameter int PULSE_WIDTH       = 8,
    parameter int DW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                 aclk,
    input  logic                 rst_n,
    input  logic                 gstart,
    input  logic [NUM_CH-1:0]    in,
    input  logic [NUM_CH*DW-1:0] delay,
    output logic [NUM_CH-1:0]    out,
    output logic [NUM_CH-1:0]    late
);

    localparam logic [DW:0]   G_LAST    = (DW+1)'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [DW-1:0] GCNT_MAX  = DW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [DW-1:0] DW_ONE    = DW'(1);
    localparam logic [DW:0]   DW1_ONE   = (DW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIRE = 2'd2,
        S_DONE = 2'd3
    } ch_state_e;

    // Elaboration-time parameter sanity checks.
    if ((GAMMA_CYCLE_WIDTH < 4) ||
        ((GAMMA_CYCLE_WIDTH & (GAMMA_CYCLE_WIDTH - 1)) != 0)) begin : g_gamma_check
        $error("mem_array: GAMMA_CYCLE_WIDTH must be a power of 2 and >= 4");
    end
    if ((PULSE_WIDTH < 1) || (PULSE_WIDTH > GAMMA_CYCLE_WIDTH)) begin : g_pw_check
        $error("mem_array: PULSE_WIDTH must be in 1..GAMMA_CYCLE_WIDTH");
    end

    // ------------------------------------------------------------------
    // Shared gamma counter.
    // gcnt_q holds the gamma time of the current cycle. The gstart cycle
    // itself is gamma time 0 (forced through g_now), so the register takes
    // 1 on the gstart edge and then counts up, saturating at G-1.
    // ------------------------------------------------------------------
    logic [DW-1:0] gcnt_q, gcnt_d;
    logic          armed_q, armed_d;
    logic [DW-1:0] g_now;

    always_comb begin
        gcnt_d  = gcnt_q;
        armed_d = armed_q;
        if (gstart) begin
            gcnt_d  = DW_ONE;
            armed_d = 1'b1;
        end else if (gcnt_q != GCNT_MAX) begin
            gcnt_d = gcnt_q + DW_ONE;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            gcnt_q  <= gcnt_d;
            armed_q <= armed_d;
        end
    end

    assign g_now = gstart ? '0 : gcnt_q;

    // ------------------------------------------------------------------
    // Per-channel delay FSMs.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_e     st_q, st_d;
        logic [DW-1:0] dly_q, dly_d;
        logic [DW-1:0] rem_q, rem_d;
        logic          out_q, out_d;
        logic          late_q, late_d;
        logic [DW-1:0] dly_use;
        logic [DW:0]   fire_t;
        logic          capture;
`ifdef MEM_ARRAY_PULSE_EN
        localparam logic [DW-1:0] PW_LAST = DW'(PULSE_WIDTH - 1);
        logic [DW-1:0] pcnt_q, pcnt_d;
`endif

        // In the gstart cycle the freshly presented delay is the one that
        // applies to a same-cycle capture.
        assign dly_use = gstart ? delay[c*DW +: DW] : dly_q;
        // DW+1 bits: g + 1 + D can reach 2G-1 and must never wrap.
        assign fire_t  = {1'b0, g_now} + {1'b0, dly_use} + DW1_ONE;

        always_comb begin
            st_d    = st_q;
            dly_d   = dly_q;
            rem_d   = rem_q;
            out_d   = out_q;
            late_d  = 1'b0;
            capture = 1'b0;
`ifdef MEM_ARRAY_PULSE_EN
            pcnt_d  = pcnt_q;
`endif
            if (gstart) begin
                // Restart the channel; any pending or ongoing fire is lost.
                dly_d   = delay[c*DW +: DW];
                out_d   = 1'b0;
                rem_d   = '0;
                st_d    = S_IDLE;
                capture = in[c];
`ifdef MEM_ARRAY_PULSE_EN
                pcnt_d  = '0;
`endif
            end else begin
                case (st_q)
                    S_IDLE: capture = armed_q & in[c];
                    S_WAIT: begin
                        if (rem_q == '0) begin
                            st_d  = S_FIRE;
                            out_d = 1'b1;
`ifdef MEM_ARRAY_PULSE_EN
                            pcnt_d = '0;
`endif
                        end else begin
                            rem_d = rem_q - DW_ONE;
                        end
                    end
                    S_FIRE: begin
`ifdef MEM_ARRAY_PULSE_EN
                        if (pcnt_q == PW_LAST) begin
                            st_d  = S_DONE;
                            out_d = 1'b0;
                        end else begin
                            pcnt_d = pcnt_q + DW_ONE;
                        end
`endif
                    end
                    S_DONE: ;
                endcase
            end

            if (capture) begin
                if (fire_t > G_LAST) begin
                    st_d   = S_DONE;
                    late_d = 1'b1;
                end else if (dly_use == '0) begin
                    st_d  = S_FIRE;
                    out_d = 1'b1;
`ifdef MEM_ARRAY_PULSE_EN
                    pcnt_d = '0;
`endif
                end else begin
                    st_d  = S_WAIT;
                    rem_d = dly_use - DW_ONE;
                end
            end
        end

        always_ff @(posedge aclk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= S_IDLE;
                dly_q  <= '0;
                rem_q  <= '0;
                out_q  <= 1'b0;
                late_q <= 1'b0;
`ifdef MEM_ARRAY_PULSE_EN
                pcnt_q <= '0;
`endif
            end else begin
                st_q   <= st_d;
                dly_q  <= dly_d;
                rem_q  <= rem_d;
                out_q  <= out_d;
                late_q <= late_d;
`ifdef MEM_ARRAY_PULSE_EN
                pcnt_q <= pcnt_d;
`endif
            end
        end

        assign out[c]  = out_q;
        assign late[c] = late_q;
    end

endmodule

// File: tb/tb_mem_array.sv
// tb/tb_mem_array.sv - self-checking bench for mem_array with a spike-timing reference model

module tb_mem_array;

    localparam int NCH   = 8;
    localparam int G     = 128;
    localparam int PW    = 8;
    localparam int DW    = 7;
    localparam int NEVER = 1 << 30;

    logic              aclk   = 1'b0;
    logic              rst_n  = 1'b0;
    logic              gstart = 1'b0;
    logic [NCH-1:0]    in_s   = '0;
    logic [NCH*DW-1:0] delay_s = '0;
    logic [NCH-1:0]    out_s;
    logic [NCH-1:0]    late_s;

    always #5 aclk = ~aclk;

    mem_array #(
        .NUM_CH(NCH),
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(PW)
    ) dut (
        .aclk(aclk),
        .rst_n(rst_n),
        .gstart(gstart),
        .in(in_s),
        .delay(delay_s),
        .out(out_s),
        .late(late_s)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: per channel, the absolute cycle window in which out is
    // high and the absolute cycle in which late is high.
    bit m_armed;
    int m_gt;
    int m_d[NCH];
    bit m_cap[NCH];
    int f_start[NCH];
    int f_end[NCH];
    int late_at[NCH];

    logic [NCH*DW-1:0] dv_cur = '0;

    task automatic model_reset();
        m_armed = 1'b0;
        m_gt    = 0;
        for (int c = 0; c < NCH; c++) begin
            m_d[c]     = 0;
            m_cap[c]   = 1'b0;
            f_start[c] = NEVER;
            f_end[c]   = NEVER;
            late_at[c] = -1;
        end
    endtask

    task automatic model_update(input bit gs, input logic [NCH-1:0] iv, input logic [NCH*DW-1:0] dv);
        if (gs) begin
            m_gt    = 0;
            m_armed = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                if (f_end[c] > cyc + 1) f_end[c] = cyc + 1;
                m_cap[c] = 1'b0;
                m_d[c]   = int'(dv[c*DW +: DW]);
            end
        end else begin
            m_gt = (m_gt + 1 > G - 1) ? G - 1 : m_gt + 1;
        end
        for (int c = 0; c < NCH; c++) begin
            if (m_armed && iv[c] && !m_cap[c]) begin
                m_cap[c] = 1'b1;
                if (m_gt + 1 + m_d[c] > G - 1) begin
                    late_at[c] = cyc + 1;
                end else begin
                    f_start[c] = cyc + 1 + m_d[c];
`ifdef MEM_ARRAY_PULSE_EN
                    f_end[c] = f_start[c] + PW;
`else
                    f_end[c] = NEVER;
`endif
                end
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_out(input int n);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (f_start[c] <= n) && (n < f_end[c]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_late(input int n);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (late_at[c] == n);
        return v;
    endfunction

    task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // One aclk cycle: drive inputs just after the edge, compare mid-cycle,
    // then advance the model with this cycle's inputs.
    task automatic step(input bit r, input bit gs, input logic [NCH-1:0] iv);
        @(posedge aclk);
        #1;
        rst_n   = r;
        gstart  = gs;
        in_s    = iv;
        delay_s = dv_cur;
        cyc++;
        if (!r) model_reset();
        @(negedge aclk);
        check("out", out_s, exp_out(cyc));
        check("late", late_s, exp_late(cyc));
        if (r) model_update(gs, iv, dv_cur);
    endtask

    task automatic set_d(input int c, input int val);
        logic [DW-1:0] v;
        v = DW'(val);
        dv_cur[c*DW +: DW] = v;
    endtask

    function automatic int rnd_d();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(1, 8));
            2:       return int'($urandom_range(0, G - 1));
            default: return int'($urandom_range(G - 8, G - 1));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] iv;
        int len;

        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        check("reset_out", out_s, '0);
        check("reset_late", late_s, '0);

        set_d(0, 3);
        set_d(1, 0);
        set_d(2, 10);
        set_d(3, 20);
        set_d(4, 1);
        set_d(5, 60);
        set_d(6, 0);
        set_d(7, 5);

        // Not armed yet: spikes before the first gstart are ignored.
        step(1'b1, 1'b0, '1);
        step(1'b1, 1'b0, '1);

        // Gamma cycle 1.
        for (int g = 0; g < 110; g++) begin
            iv = '0;
            if (g == 0)   iv[1] = 1'b1;
            if (g == 5)   iv[0] = 1'b1;
            if (g == 2 || g == 4 || g == 6) iv[4] = 1'b1;
            if (g == 100) iv[3] = 1'b1;
            step(1'b1, g == 0, iv);
            if (g == 1) check1("ch1_d0_rise", out_s[1], 1'b1);
            if (g == 3) check1("ch4_before", out_s[4], 1'b0);
            if (g == 4) check1("ch4_rise", out_s[4], 1'b1);
            if (g == 8) check1("ch0_before", out_s[0], 1'b0);
            if (g == 9) check1("ch0_rise", out_s[0], 1'b1);
            if (g == 9) check1("ch0_late", late_s[0], 1'b0);
`ifdef MEM_ARRAY_PULSE_EN
            if (g == 16) check1("ch0_pulse_hi", out_s[0], 1'b1);
            if (g == 17) check1("ch0_pulse_fall", out_s[0], 1'b0);
`endif
        end

        // Gamma cycle 2: gstart discards ch3's pending fire, runs past G-1.
        for (int g = 0; g < 132; g++) begin
            iv = '0;
            if (g == 0)   iv[1] = 1'b1;
            if (g == 5)   iv[3] = 1'b1;
            if (g == 120) iv[2] = 1'b1;
            if (g == 129) iv[6] = 1'b1;
            step(1'b1, g == 0, iv);
            if (g == 20)  check1("ch3_discarded", out_s[3], 1'b0);
            if (g == 26)  check1("ch3_fresh_rise", out_s[3], 1'b1);
            if (g == 121) check1("ch2_late_hi", late_s[2], 1'b1);
            if (g == 122) check1("ch2_late_lo", late_s[2], 1'b0);
            if (g == 122) check1("ch2_no_out", out_s[2], 1'b0);
            if (g == 130) check1("ch6_sat_late", late_s[6], 1'b1);
        end

        // Gamma cycle 3: reset while ch5 waits, then spikes before any gstart.
        for (int g = 0; g < 50; g++) begin
            iv = '0;
            if (g == 10) iv[5] = 1'b1;
            step(1'b1, g == 0, iv);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '1);
        check("post_reset_out", out_s, '0);
        check("post_reset_late", late_s, '0);

        // Gamma cycle 4: normal behaviour resumes.
        for (int g = 0; g < 80; g++) begin
            iv = '0;
            if (g == 3) iv[5] = 1'b1;
            step(1'b1, g == 0, iv);
            if (g == 63) check1("ch5_before", out_s[5], 1'b0);
            if (g == 64) check1("ch5_rise", out_s[5], 1'b1);
        end

        // Randomized gamma cycles with varying lengths and one reset.
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < NCH; c++) set_d(c, rnd_d());
            len = int'($urandom_range(40, 140));
            for (int g = 0; g < len; g++) begin
                for (int c = 0; c < NCH; c++) iv[c] = ($urandom_range(0, 7) == 0);
                step(!(k == 3 && (g == 30 || g == 31)), g == 0, iv);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
